// File: rtl/lane_rx_deserializer_pkg.sv
// Shared lane PHY definitions: symbol constants and receive FSM state encoding.
// Used by the lane transmitter, this deserializer and the un-striping stage.
package lane_rx_deserializer_pkg;

  localparam logic [7:0]  PHY_COM_SYMBOL  = 8'hBC;
  localparam logic [7:0]  PHY_IDLE_SYMBOL = 8'h7C;
  localparam int unsigned PHY_LOCK_COUNT  = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } lane_state_e;

  // True for fill symbols that must not be delivered as data.
  function automatic logic is_fill(input logic [7:0] sym,
                                   input logic [7:0] com,
                                   input logic [7:0] idle);
    return (sym == com) || (sym == idle);
  endfunction

endpackage

// File: rtl/lane_rx_deserializer_if.sv
// Lane receive bundle.
//   serial_in   : serial bit stream, MSB of each byte first
//   data_out    : last received data byte
//   valid_out   : data_out holds a data (non-fill) byte
//   byte_strobe : one-cycle pulse per byte boundary while active
//   active      : lane locked and delivering data
// master = source/consumer side, slave = deserializer.
interface lane_rx_deserializer_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (output serial_in,
                  input  data_out, valid_out, byte_strobe, active);
  modport slave  (input  serial_in,
                  output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/lane_rx_deserializer_shift8.sv
// lane_shift8: serial shift register plus 3-bit bit counter.
//   clk_i, rst_n_i : clock, async active-low reset
//   serial_i       : incoming bit
//   clr_i          : synchronous bit counter clear (counter reads 0 next cycle)
//   window_o       : byte completing on this edge, {sr[6:0], serial_i}
//   boundary_o     : this edge closes a byte (bit counter == 7)
module lane_shift8 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       serial_i,
  input  logic       clr_i,
  output logic [7:0] window_o,
  output logic       boundary_o
);

  // Only the low seven bits of the 8-bit shift register are ever observed,
  // so the oldest bit is not stored.
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= {sr_q[5:0], serial_i};
      bit_cnt_q <= clr_i ? '0 : bit_cnt_q + 3'd1;
    end
  end

  assign window_o   = {sr_q, serial_i};
  assign boundary_o = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/lane_rx_deserializer.sv
// lane_rx_deserializer: per-lane receive front end.
// Hunts for the COM symbol on every bit, then checks for LOCK_COUNT COMs on
// consecutive byte boundaries before going active. Once active, every byte
// boundary pulses byte_strobe; data bytes are delivered with valid_out,
// COM/IDLE fill drops valid_out and holds data_out.
//   clk   : bit clock
//   reset : async active-low reset
//   lane  : serial input and byte outputs (slave modport)
module lane_rx_deserializer
  import lane_rx_deserializer_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL  = PHY_COM_SYMBOL,
  parameter logic [7:0]  IDLE_SYMBOL = PHY_IDLE_SYMBOL,
  parameter int unsigned LOCK_COUNT  = PHY_LOCK_COUNT
) (
  input  logic                          clk,
  input  logic                          reset,
  lane_rx_deserializer_if.slave         lane
);

  localparam logic [3:0] LOCK_CNT = LOCK_COUNT[3:0];

  lane_state_e state_q, state_d;
  logic [3:0]  com_cnt_q, com_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;
  logic        clr;
  logic [7:0]  window;
  logic        boundary;

  lane_shift8 u_shift (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .serial_i   (lane.serial_in),
    .clr_i      (clr),
    .window_o   (window),
    .boundary_o (boundary)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      SEARCH: begin
        // Bit counter is free-running here; a match re-phases it so the
        // next boundary lands 8 edges later.
        if (window == COM_SYMBOL) begin
          clr       = 1'b1;
          com_cnt_d = 4'd1;
          state_d   = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (window == COM_SYMBOL) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == LOCK_CNT) state_d = ACTIVE;
          end else begin
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_fill(window, COM_SYMBOL, IDLE_SYMBOL)) begin
            valid_d = 1'b0;
          end else begin
            data_d  = window;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = (state_q == ACTIVE);

endmodule

// File: doc/lane_rx_deserializer.md
Name: lane_rx_deserializer

Overview:
- Per-lane receive front end of the phy. Accepts one serial bit per clk (clk_32f domain), locates byte boundaries by hunting for the COM symbol, and declares the lane active after a programmable run of aligned COMs.
- Once active, it delivers each received byte with a valid flag and filters out COM/IDLE fill symbols.
- Sits directly downstream of the lane parallel-to-serial transmitter and upstream of the lane un-striping logic. That logic consumes data_out/valid_out at clk_4f.

Parameters:
- COM_SYMBOL, 8'hBC, alignment/comma symbol
- IDLE_SYMBOL, 8'h7C, idle fill symbol
- LOCK_COUNT, 4, consecutive aligned COMs required to enter ACTIVE (range 1..15)

Ports:
- clk  input  1  bit clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- serial_in  input  1  serial data, MSB of each byte first
- data_out  output  8  last received data byte
- valid_out  output  1  data_out holds a data (non-COM, non-IDLE) byte
- byte_strobe  output  1  one-cycle pulse at each byte boundary once aligned
- active  output  1  lane locked and delivering data

Behaviour:
- Reset (reset==0, async): state=SEARCH, shift reg=0, bit_cnt=0, com_cnt=0. Outputs: data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
- Shift register: every edge, sr <= {sr[6:0], serial_in}. The window is {sr[6:0], serial_in}, i.e. the byte completing on this edge.
- Byte boundary: an edge where bit_cnt==7. bit_cnt is 3 bits and wraps 7->0.
- SEARCH:
  - Window compared every edge; bit_cnt ignored.
  - window==COM_SYMBOL: bit_cnt<=0, com_cnt<=1.
    - LOCK_COUNT==1: go to ACTIVE.
    - Otherwise: go to ALIGN.
- ALIGN: compare only at byte boundaries.
  - window==COM: com_cnt++; if com_cnt+1==LOCK_COUNT, go to ACTIVE.
  - Any other value: go to SEARCH, com_cnt<=0.
    - That same window is not re-checked for COM; it is not COM by definition.
- ACTIVE:
  - At each byte boundary: byte_strobe=1 for one cycle.
    - window is COM or IDLE: valid_out<=0, data_out holds its previous value.
    - Otherwise: data_out<=window, valid_out<=1.
  - Between boundaries, data_out/valid_out hold.
  - No loss-of-lock detection; only reset leaves ACTIVE.
- Registered outputs and latency:
  - active<=1 on the same edge that samples the last bit of the LOCK_COUNT-th COM.
  - data_out/valid_out/byte_strobe update on the edge that samples the byte's 8th bit.
  - Latency from LSB sampled to data_out is 0 cycles (registered at that edge). Data remains stable for 8 cycles.
- byte_strobe is 0 in SEARCH/ALIGN. In ACTIVE, the first strobe is on the first boundary after entry, 8 edges later.
- Reset mid-operation: immediate return to reset values; realignment starts from scratch.
- Back-to-back COM patterns straddling bits (e.g. ...BC overlapping shift) in SEARCH: the first match wins. After that, only aligned boundaries count.

Decomposition:
- Shared package/include (phy_defs): COM_SYMBOL 8'hBC, IDLE_SYMBOL 8'h7C, state encodings SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2. These are shared with the transmitter and the un-striping stage.
- One natural sub-module, lane_shift8: the 8-bit shift register plus 3-bit bit counter with synchronous counter clear. It exports the window and the boundary flag.
- The FSM and output registers stay in lane_rx_deserializer.

Test Plan:
1. Reset: hold reset=0 with random serial_in. Required: data_out=00, valid_out=0, byte_strobe=0, active=0 throughout.
2. Offset alignment: 3 garbage bits (101), then BC,BC,BC,BC, then A5. Required:
   - active rises on the edge of the 32nd bit of the COM run.
   - 8 edges later: byte_strobe=1, data_out=A5, valid_out=1.
3. Fill filtering: in ACTIVE send 7C,BC,3C. Required:
   - 7C and BC: valid_out=0 with data_out held at the previous byte.
   - 3C: data_out=3C, valid_out=1.
   - byte_strobe pulses on all three boundaries.
4. Broken lock: BC,BC,55,BC,BC,BC,BC,11. Required:
   - 55 returns the FSM to SEARCH.
   - active rises only after the 4th COM of the second run.
   - data_out=11, valid_out=1.
5. Reset mid-ACTIVE: assert reset during bit 4 of a data byte. Required:
   - All outputs clear asynchronously.
   - After release, 4 COMs are needed again before active=1.
6. LOCK_COUNT=1 build: a single BC followed by 42. Required: active=1 at the end of BC, data_out=42, valid_out=1.
